// File: rtl/seqdet_pkg.sv
// seqdet_pkg -- shared constants, types and helpers for seq_detector_param.
//
//   DEF_PATTERN / DEF_LEN : pattern and length loaded at reset; together they
//                           make the block behave as the legacy "101" detector.
//   CFG_PAT_W / CFG_LEN_W : default widths for the configuration record.
//   seqdet_cfg_t          : configuration record (pattern, len, overlap).
//   clamp_len()           : maps a raw length onto the legal range 1..max_len.
package seqdet_pkg;

  localparam logic [2:0]  DEF_PATTERN = 3'b101;
  localparam int unsigned DEF_LEN     = 3;

  localparam int unsigned CFG_PAT_W = 8;
  localparam int unsigned CFG_LEN_W = $clog2(CFG_PAT_W + 1);

  typedef struct packed {
    logic [CFG_PAT_W-1:0] pattern;
    logic [CFG_LEN_W-1:0] len;
    logic                 overlap;
  } seqdet_cfg_t;

  // A length of 0 means a single-bit pattern. Lengths above the hardware
  // maximum are reduced to that maximum.
  function automatic int unsigned clamp_len(input int unsigned raw,
                                            input int unsigned max_len);
    if (raw == 0)
      return 1;
    else if (raw > max_len)
      return max_len;
    else
      return raw;
  endfunction

endpackage

// File: rtl/seqdet_sat_counter.sv
// seqdet_sat_counter -- saturating up-counter for matches.
//
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset (count -> 0)
//   inc    : add one, unless the counter is already at all-ones
//   clr    : synchronous clear; it wins over a simultaneous inc
//   count  : current count, CNT_W bits
module seqdet_sat_counter
  import seqdet_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      count <= '0;
    else if (clr)
      count <= '0;
    else if (inc && (count != '1))
      count <= count + 1'b1;
  end

endmodule

// File: rtl/seq_detector_param.sv
// seq_detector_param -- programmable serial pattern detector.
//
// Matches a run-time pattern of 1..PAT_W bits against a qualified serial
// stream. The pattern's bit [len-1] is the first bit received, bit [0] the
// last. Overlapping or non-overlapping detection is selectable.
//
// Optional feature macro: SEQDET_COUNT_EN adds the match_count output and a
// saturating match counter (cleared by cnt_clr). Without it cnt_clr is
// ignored and detection is unchanged.
//
// Ports:
//   clk          : rising-edge clock
//   rst_n        : asynchronous active-low reset
//   in_valid     : in_bit is sampled only when high
//   in_bit       : serial data bit
//   cfg_load     : latch cfg_pattern/cfg_len/cfg_overlap and clear history
//   cfg_pattern  : pattern, PAT_W bits (bits at/above len are ignored)
//   cfg_len      : pattern length; 0 -> 1, above PAT_W -> PAT_W
//   cfg_overlap  : 1 = overlapping, 0 = non-overlapping detection
//   cnt_clr      : synchronous clear of match_count
//   detected     : registered one-cycle match pulse
//   match_count  : saturating match count (SEQDET_COUNT_EN only)
module seq_detector_param
  import seqdet_pkg::*;
#(
  parameter int PAT_W = 8,
  parameter int CNT_W = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  input  logic                         in_bit,
  input  logic                         cfg_load,
  input  logic [PAT_W-1:0]             cfg_pattern,
  input  logic [$clog2(PAT_W+1)-1:0]   cfg_len,
  input  logic                         cfg_overlap,
  input  logic                         cnt_clr,
  output logic                         detected
`ifdef SEQDET_COUNT_EN
  ,
  output logic [CNT_W-1:0]             match_count
`endif
);

  localparam int LEN_W = $clog2(PAT_W + 1);
  localparam logic [LEN_W-1:0] FULL    = LEN_W'(PAT_W);
  localparam logic [LEN_W-1:0] RST_LEN = LEN_W'(clamp_len(DEF_LEN, PAT_W));
  localparam logic [PAT_W-1:0] RST_PAT = PAT_W'(DEF_PATTERN);

  logic [PAT_W-1:0] hist_reg;
  logic [LEN_W-1:0] fill_reg;
  logic [PAT_W-1:0] pat_reg;
  logic [LEN_W-1:0] len_reg;
  logic             ovl_reg;
  logic             det_reg;

  logic [PAT_W-1:0] hist_next;
  logic [LEN_W-1:0] fill_next;
  logic [LEN_W-1:0] len_clamped;
  logic [PAT_W-1:0] len_mask;
  logic             raw_match;
  logic             match;

  // Newest bit enters at [0].
  generate
    if (PAT_W == 1) begin : g_hist_1
      assign hist_next = in_bit;
    end else begin : g_hist_n
      assign hist_next = {hist_reg[PAT_W-2:0], in_bit};
    end
  endgenerate

  // Only the lowest len bits of history and pattern take part in the compare.
  genvar gi;
  generate
    for (gi = 0; gi < PAT_W; gi++) begin : g_mask
      assign len_mask[gi] = (gi < int'(len_reg));
    end
  endgenerate

  assign fill_next   = (fill_reg == FULL) ? fill_reg : fill_reg + 1'b1;
  assign len_clamped = LEN_W'(clamp_len(32'(cfg_len), PAT_W));

  // fill gates the compare so stale history (after reset, cfg_load or a
  // non-overlapping match) can never complete a pattern.
  assign raw_match = (fill_next >= len_reg) &&
                     (((hist_next ^ pat_reg) & len_mask) == '0);
  assign match     = in_valid && !cfg_load && raw_match;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_reg <= '0;
      fill_reg <= '0;
      pat_reg  <= RST_PAT;
      len_reg  <= RST_LEN;
      ovl_reg  <= 1'b1;
      det_reg  <= 1'b0;
    end else if (cfg_load) begin
      // Any data bit offered in the same cycle is dropped.
      pat_reg  <= cfg_pattern;
      len_reg  <= len_clamped;
      ovl_reg  <= cfg_overlap;
      hist_reg <= '0;
      fill_reg <= '0;
      det_reg  <= 1'b0;
    end else if (in_valid) begin
      hist_reg <= hist_next;
      // Non-overlapping: restart the fill so the next match needs len new bits.
      fill_reg <= (match && !ovl_reg) ? '0 : fill_next;
      det_reg  <= match;
    end else begin
      det_reg  <= 1'b0;
    end
  end

  assign detected = det_reg;

`ifdef SEQDET_COUNT_EN
  seqdet_sat_counter #(
    .CNT_W (CNT_W)
  ) u_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (match),
    .clr   (cnt_clr),
    .count (match_count)
  );
`else
  // cnt_clr and CNT_W have no function without the counter.
  logic unused_cnt;
  assign unused_cnt = cnt_clr ^ (CNT_W > 0);
`endif

endmodule

// File: tb/tb_seq_detector_param.sv
// tb_seq_detector_param -- scoreboard bench for seq_detector_param.
//
// Stimulus tasks drive one cycle at a time on the falling edge and push the
// hand-computed expected response for that cycle into a queue. A monitor
// samples the outputs 1 ns after each rising edge, pops one entry and
// compares. Count checks are active when SEQDET_COUNT_EN is defined.
module tb_seq_detector_param;

  localparam int PAT_W = 8;
  localparam int CNT_W = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_bit = 1'b0;
  logic       cfg_load = 1'b0;
  logic [7:0] cfg_pattern = '0;
  logic [3:0] cfg_len = '0;
  logic       cfg_overlap = 1'b0;
  logic       cnt_clr = 1'b0;
  logic       detected;
`ifdef SEQDET_COUNT_EN
  logic [CNT_W-1:0] match_count;
`endif

  seq_detector_param #(
    .PAT_W (PAT_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_bit      (in_bit),
    .cfg_load    (cfg_load),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_overlap (cfg_overlap),
    .cnt_clr     (cnt_clr),
    .detected    (detected)
`ifdef SEQDET_COUNT_EN
    ,
    .match_count (match_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       exp_det;
    bit         chk_cnt;
    logic [7:0] exp_cnt;
    string      tag;
  } exp_t;

  exp_t sb_q[$];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic push(input logic d, input bit cc, input logic [7:0] ce,
                      input string tag);
    exp_t e;
    e.exp_det = d;
    e.chk_cnt = cc;
    e.exp_cnt = ce;
    e.tag     = tag;
    sb_q.push_back(e);
  endtask

  task automatic step(input logic v, input logic b, input logic clr,
                      input logic d, input bit cc, input logic [7:0] ce,
                      input string tag);
    @(negedge clk);
    in_valid = v;
    in_bit   = b;
    cnt_clr  = clr;
    cfg_load = 1'b0;
    push(d, cc, ce, tag);
  endtask

  // The load cycle also offers a valid '1' bit, which must be discarded.
  task automatic load(input logic [7:0] p, input logic [3:0] l, input logic o,
                      input logic [7:0] ce, input string tag);
    @(negedge clk);
    cfg_load    = 1'b1;
    cfg_pattern = p;
    cfg_len     = l;
    cfg_overlap = o;
    in_valid    = 1'b1;
    in_bit      = 1'b1;
    cnt_clr     = 1'b0;
    push(1'b0, 1'b1, ce, tag);
  endtask

  // bits[n-1] is sent first; dm[i] is the expected pulse after bit i.
  task automatic send(input logic [31:0] bits, input int n,
                      input logic [31:0] dm, input logic [7:0] ce_end,
                      input string tag);
    for (int i = 0; i < n; i++)
      step(1'b1, bits[n-1-i], 1'b0, dm[i], (i == n - 1), ce_end,
           $sformatf("%s[%0d]", tag, i));
  endtask

  task automatic pulse_reset(input string tag);
    @(negedge clk);
    rst_n    = 1'b0;
    in_valid = 1'b0;
    cfg_load = 1'b0;
    cnt_clr  = 1'b0;
    push(1'b0, 1'b1, 8'd0, tag);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: one comparison set per scoreboard entry.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        n_total++;
        if (detected === e.exp_det)
          n_pass++;
        else
          $display("FAIL %s detected got %0b expected %0b", e.tag, detected, e.exp_det);
`ifdef SEQDET_COUNT_EN
        if (e.chk_cnt) begin
          n_total++;
          if (match_count === e.exp_cnt)
            n_pass++;
          else
            $display("FAIL %s match_count got %0d expected %0d", e.tag, match_count, e.exp_cnt);
        end
`endif
        $display("txn %s detected=%0b expected=%0b", e.tag, detected, e.exp_det);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    pulse_reset("reset");

    // Defaults (101, overlapping).
    send(32'hB52A, 16, 32'h50A4, 8'd5, "t1_ovl");

    // 101 non-overlapping.
    load(8'h05, 4'd3, 1'b0, 8'd5, "t2_cfg");
    send(32'hB52A, 16, 32'h1024, 8'd8, "t2_novl");

    // 1101 overlapping; upper pattern bits are junk and must be ignored.
    load(8'hFD, 4'd4, 1'b1, 8'd8, "t3_cfg");
    send(32'h6D, 7, 32'h48, 8'd10, "t3_1101");

    // 101 with two idle cycles between valid bits.
    load(8'h05, 4'd3, 1'b1, 8'd10, "t4_cfg");
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, "t4_b0");
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, "t4_gap0");
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, "t4_gap1");
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, "t4_b1");
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, "t4_gap2");
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, "t4_gap3");
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'd11, "t4_b2");

    // Reset after "10" loses the partial match; defaults restored.
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, "t5_b0");
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, "t5_b1");
    pulse_reset("t5_rst");
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'd0, "t5_after");
    send(32'h5, 3, 32'h4, 8'd1, "t5_full");

    // len=0 means 1, non-overlapping: consecutive pulses on each '1'.
    load(8'h01, 4'd0, 1'b0, 8'd1, "t6_cfg");
    send(32'hD, 4, 32'hB, 8'd4, "t6_len0");

    // len=15 clamps to 8.
    load(8'hA5, 4'd15, 1'b1, 8'd4, "t7_cfg");
    send(32'h1A5, 9, 32'h100, 8'd5, "t7_clamp");

    // Counter saturation, then cnt_clr beating a simultaneous match.
    load(8'h01, 4'd1, 1'b1, 8'd5, "t8_cfg");
    for (int i = 0; i < 260; i++)
      step(1'b1, 1'b1, 1'b0, 1'b1, (i == 259), 8'd255, $sformatf("t8_sat[%0d]", i));
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'd0, "t8_clr");
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'd1, "t8_after");
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd1, "t8_idle");

    repeat (5) @(posedge clk);
    #2;
    if (sb_q.size() != 0) begin
      n_total++;
      $display("FAIL drain queue got %0d entries expected 0", sb_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
